div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low: rst=0 forces reset state immediately, independent of clk.
REQ-004 start  input  1  EX-stage request to begin a divide; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = DIV/REM (signed), 0 = DIVU/REMU (unsigned); sampled with start.
REQ-006 rem_sel  input  1  1 = return remainder, 0 = return quotient; sampled with start.
REQ-007 dividend  input  WIDTH  operand 1 (s1data after forwarding); sampled with start.
REQ-008 divisor  input  WIDTH  operand 2 (s2data after forwarding); sampled with start.
REQ-009 annul  input  1  pipeline flush; abandons any operation in progress.
REQ-010 stallreq  output  1  request to freeze the pipeline while a divide is pending.
REQ-011 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-012 result  output  WIDTH  quotient or remainder; held from done until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE; encoding free.
REQ-014 IDLE: start=1 and annul=0 SHALL latch all operands/controls; next state DONE if divisor==0 or signed overflow, else CALC with counter cleared.
REQ-015 CALC SHALL run exactly WIDTH cycles of restoring shift-subtract on operand magnitudes, one quotient bit per cycle, MSB first; counter increments each cycle; CALC->FIX when counter reaches WIDTH-1.
REQ-016 FIX SHALL apply signs in one cycle: quotient negated if signed_op and operand signs differ; remainder takes dividend's sign if signed_op; FIX->DONE.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, load result, then go to IDLE.
REQ-018 Normal latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH+1 (cycle 34 for WIDTH=32); back-to-back starts accepted in the cycle after done.
REQ-019 Divisor zero: quotient all ones, remainder = dividend (both signednesses); done in the cycle after E0.
REQ-020 Signed overflow (dividend=-2^(WIDTH-1), divisor=-1, signed_op=1): quotient = dividend, remainder 0; done in the cycle after E0.
REQ-021 stallreq SHALL be combinational: 1 when (IDLE and start and not annul) or state is CALC or FIX; 0 in IDLE without start, and 0 in DONE so the pipeline advances and captures result.
REQ-022 start in CALC/FIX/DONE SHALL be ignored; operands latched at start SHALL not change mid-operation regardless of input changes.
REQ-023 annul=1 in any state SHALL force IDLE at the next edge, suppress done, and leave result unchanged; annul and start together in IDLE SHALL not start.
REQ-024 done SHALL never be 1 outside DONE; result SHALL change only on entry to DONE.

Reset
REQ-025 rst=0 SHALL immediately set state IDLE, counter 0, done 0, stallreq 0, result 0, all operand/partial registers 0.
REQ-026 rst asserted mid-CALC SHALL abandon the operation with no done pulse; after rst=1 the block SHALL accept start on the first clock edge.

Verification
REQ-027 Unsigned: start, signed_op=0, rem_sel=0, 100/7 -> stallreq high 34 cycles, done in cycle 34, result 14; repeat rem_sel=1 -> 2.
REQ-028 Signed: -7/2, signed_op=1 -> quotient 0xFFFFFFFD (-3); rem_sel=1 -> 0xFFFFFFFF (-1).
REQ-029 Divide by zero: 0x1234/0, rem_sel=0 -> 0xFFFFFFFF in the cycle after start; rem_sel=1 -> 0x00001234; stallreq high for one cycle only.
REQ-030 Overflow: 0x80000000/0xFFFFFFFF signed -> quotient 0x80000000, remainder 0, one-cycle latency.
REQ-031 annul at CALC cycle 10 -> IDLE next edge, no done, result keeps prior value; fresh start then completes normally.
REQ-032 rst=0 asynchronously mid-CALC -> outputs zero without clock edge; start after release -> correct result at 34-cycle latency.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider for a pipelined integer core: signed/unsigned
// quotient or remainder, one quotient bit per cycle, with flush and stall handshakes.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic             rem_sel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             annul,
   output logic             stallreq,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             rem_sel_q, rem_sel_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             ovf;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      rem_sel_d = rem_sel_q;
      result_d  = result_q;

      // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      ovf     = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

      unique case (state_q)
         IDLE: begin
            if (start && !annul) begin
               rem_sel_d = rem_sel;
               q_neg_d   = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               r_neg_d   = signed_op & dividend[WIDTH-1];
               quo_d     = mag(dividend, signed_op);
               dvs_d     = mag(divisor, signed_op);
               rem_d     = '0;
               cnt_d     = '0;
               if (divisor == '0) begin
                  result_d = rem_sel ? dividend : '1;
                  state_d  = DONE;
               end else if (ovf) begin
                  result_d = rem_sel ? '0 : dividend;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            result_d = rem_sel_q ? (r_neg_q ? -rem_q : rem_q)
                                 : (q_neg_q ? -quo_q : quo_q);
            state_d  = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A flush wins over everything: abandon the operation and keep the old result.
      if (annul) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         rem_sel_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         rem_sel_q <= rem_sel_d;
         result_q  <= result_d;
      end
   end

   // Gated by rst so the pipeline is released the instant reset is applied.
   assign stallreq = rst && (((state_q == IDLE) && start && !annul) ||
                             (state_q == CALC) || (state_q == FIX));
   assign done     = (state_q == DONE) && !annul;
   assign result   = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operations
// checked against an arithmetic reference model, latency and stall counts included.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic        rem_sel;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic        stallreq;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   div_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .signed_op(signed_op),
      .rem_sel  (rem_sel),
      .dividend (dividend),
      .divisor  (divisor),
      .annul    (annul),
      .stallreq (stallreq),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Division semantics of a RISC-V style core, computed with plain arithmetic.
   function automatic logic [31:0] ref_div(input logic s, input logic rs,
                                           input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return rs ? a : 32'hFFFF_FFFF;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rs ? 32'd0 : a;
      if (s) return rs ? 32'(sa % sb) : 32'(sa / sb);
      return rs ? a % b : a / b;
   endfunction

   // Called just after a negedge with the DUT idle; returns one cycle after done, DUT idle.
   task automatic run_op(input string tag, input logic s, input logic rs,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      int          stalls;
      bit          got;
      exp     = ref_div(s, rs, a, b);
      exp_lat = (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
      start     = 1'b1;
      signed_op = s;
      rem_sel   = rs;
      dividend  = a;
      divisor   = b;
      #1;
      check({tag, "_stall_start"}, stallreq, 1);
      stalls = 1;
      lat    = 0;
      got    = 0;
      @(posedge clk);
      for (int k = 1; k <= 100 && !got; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            lat = k;
            check({tag, "_result"}, result, exp);
            check({tag, "_stall_done"}, stallreq, 0);
            start = 1'b0;
         end else begin
            if (stallreq) stalls++;
            // Noise on every input while busy must not disturb the latched operation.
            start     = (k < 20) ? 1'($urandom % 2) : 1'b0;
            signed_op = 1'($urandom);
            rem_sel   = 1'($urandom);
            dividend  = $urandom;
            divisor   = $urandom;
         end
      end
      check({tag, "_done_seen"}, 32'(got), 1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_stall_cycles"}, stalls, exp_lat);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_held"}, result, exp);
   endtask

   initial begin
      logic [31:0] prior;
      int          pulses;
      logic        s;
      logic        rs;
      logic [31:0] a;
      logic [31:0] b;

      rst       = 1'b0;
      start     = 1'b0;
      signed_op = 1'b0;
      rem_sel   = 1'b0;
      dividend  = '0;
      divisor   = '0;
      annul     = 1'b0;
      #3;
      check("reset_result", result, 0);
      check("reset_done", done, 0);
      check("reset_stall", stallreq, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_op("u_quo", 1'b0, 1'b0, 32'd100, 32'd7);
      run_op("u_rem", 1'b0, 1'b1, 32'd100, 32'd7);
      run_op("s_quo", 1'b1, 1'b0, -32'sd7, 32'd2);
      run_op("s_rem", 1'b1, 1'b1, -32'sd7, 32'd2);
      run_op("dz_quo", 1'b0, 1'b0, 32'h0000_1234, 32'd0);
      run_op("dz_rem", 1'b0, 1'b1, 32'h0000_1234, 32'd0);
      run_op("dz_s_rem", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0);
      run_op("ovf_quo", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("ovf_rem", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("u_big", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("s_min_2", 1'b1, 1'b0, 32'h8000_0000, 32'd2);

      // Flush at the tenth divide cycle: no done, result untouched, block idle.
      prior     = result;
      start     = 1'b1;
      signed_op = 1'b0;
      rem_sel   = 1'b0;
      dividend  = 32'd999;
      divisor   = 32'd10;
      @(posedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      check("annul_stall", stallreq, 0);
      check("annul_result", result, prior);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("annul_no_done", pulses, 0);
      check("annul_result_kept", result, prior);

      // Start together with annul must not begin an operation.
      start = 1'b1;
      annul = 1'b1;
      #1;
      check("annul_start_stall", stallreq, 0);
      @(negedge clk);
      start = 1'b0;
      annul = 1'b0;
      #1;
      check("annul_start_idle", stallreq, 0);
      @(negedge clk);
      run_op("post_annul", 1'b0, 1'b0, 32'd999, 32'd10);

      // Asynchronous reset in the middle of a divide.
      start     = 1'b1;
      signed_op = 1'b1;
      rem_sel   = 1'b0;
      dividend  = 32'd12345;
      divisor   = 32'd17;
      @(posedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_result", result, 0);
      check("arst_stall", stallreq, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      run_op("post_rst", 1'b1, 1'b0, 32'd12345, 32'd17);

      for (int i = 0; i < 20; i++) begin
         s  = 1'($urandom);
         rs = 1'($urandom);
         a  = $urandom;
         case ($urandom % 8)
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), s, rs, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
